// File: rtl/mem_access_unit.sv
// MEM-stage access unit: sub-word loads with extension, sub-word stores via a 3-cycle read-modify-write.
// Optional macro MEM_ACCESS_MISALIGN_TRAP_EN flags misaligned half/word accesses instead of force-aligning them.
module mem_access_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_uns,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              stall,
   output logic [DATA_W-1:0] load_data,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wdata,
   output logic              dm_we,
   input  logic [DATA_W-1:0] dm_rdata,
   output logic              misalign,
   output logic [ADDR_W-1:0] bad_addr
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RMW_RD = 2'd1,
      RMW_WR = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] word_q;
   logic [1:0]        size_q;
   logic              mis_s;
   logic              stall_s;
   logic              dm_we_s;

   // Select the addressed lane of a word and sign- or zero-extend it.
   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lo, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = 8'(word >> {lo, 3'b000});
      h = 16'(word >> {lo[1], 4'b0000});
      case (size)
         2'b00:   res = uns ? {24'd0, b} : {{24{b[7]}}, b};
         2'b01:   res = uns ? {16'd0, h} : {{16{h[15]}}, h};
         default: res = word;
      endcase
      return res;
   endfunction

   // Replace the addressed byte or half of a word with right-justified store data.
   function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] lo);
      logic [31:0] mask;
      logic [31:0] data;
      case (size)
         2'b00: begin
            mask = 32'h0000_00FF << {lo, 3'b000};
            data = {24'd0, wdata[7:0]} << {lo, 3'b000};
         end
         2'b01: begin
            mask = 32'h0000_FFFF << {lo[1], 4'b0000};
            data = {16'd0, wdata[15:0]} << {lo[1], 4'b0000};
         end
         default: begin
            mask = 32'hFFFF_FFFF;
            data = wdata;
         end
      endcase
      return (word & ~mask) | (data & mask);
   endfunction

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   logic [ADDR_W-1:0] bad_addr_q;

   assign mis_s = (state == IDLE) && req_valid &&
                  (((req_size == 2'b01) && req_addr[0]) ||
                   (req_size[1] && (req_addr[1:0] != 2'b00)));

   // Remember the most recent faulting address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bad_addr_q <= '0;
      end else if (mis_s) begin
         bad_addr_q <= req_addr;
      end
   end

   assign bad_addr = bad_addr_q;
   assign misalign = mis_s & rst_n;
`else
   assign mis_s    = 1'b0;
   assign bad_addr = '0;
   assign misalign = 1'b0;
`endif

   // Next-state and datapath steering for the read-modify-write sequencer.
   always_comb begin
      state_nxt = state;
      dm_addr   = req_addr;
      dm_wdata  = req_wdata;
      dm_we_s   = 1'b0;
      stall_s   = 1'b0;
      load_data = '0;
      case (state)
         IDLE: begin
            if (req_valid && !mis_s) begin
               if (!req_we) begin
                  load_data = load_extend(dm_rdata, req_size, req_addr[1:0], req_uns);
               end else if (req_size[1]) begin
                  dm_we_s = 1'b1;
               end else begin
                  stall_s   = 1'b1;
                  state_nxt = RMW_RD;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         RMW_RD: begin
            dm_addr   = addr_q;
            dm_wdata  = word_q;
            stall_s   = 1'b1;
            state_nxt = RMW_WR;
         end
         RMW_WR: begin
            dm_addr   = addr_q;
            dm_wdata  = lane_merge(word_q, wdata_q, size_q, addr_q[1:0]);
            dm_we_s   = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Reset must silence memory writes and release the pipeline immediately, even mid-RMW.
   assign stall = stall_s & rst_n;
   assign dm_we = dm_we_s & rst_n;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Capture the sub-word store request, then the old memory word during RMW_RD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= 2'b00;
         word_q  <= '0;
      end else begin
         if ((state == IDLE) && (state_nxt == RMW_RD)) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
         end
         if (state == RMW_RD) begin
            word_q <= dm_rdata;
         end
      end
   end

endmodule
